// File: rtl/avr_uart.sv
// avr_uart: memory-mapped 8N1 UART on the AVR data bus, DATA at BASE, STATUS at BASE+1.
// Define UART_RX_FIFO_EN for a DEPTH-entry RX FIFO; otherwise one holding byte is used.
module avr_uart #(
  parameter logic [15:0] BASE    = 16'h0020,
  parameter int          DIVISOR = 217,
  parameter int          DEPTH   = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic [7:0]  d,
  input  logic        we,
  input  logic        read,
  output logic        hit,
  output logic [7:0]  q,
  input  logic        rx,
  output logic        tx,
  output logic        intr
);

  localparam logic [15:0] DIV_M1  = 16'(DIVISOR - 1);
  localparam logic [15:0] HALF_M1 = 16'(DIVISOR / 2 - 1);

  if (DIVISOR < 4 || DIVISOR > 65535 ||
      DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_param
    $error("avr_uart: illegal DIVISOR or DEPTH");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  logic sel_data;
  logic sel_stat;
  logic stat_wr;

  assign sel_data = address == BASE;
  assign sel_stat = address == BASE + 16'd1;
  assign stat_wr  = we && sel_stat;

  // ---------------- transmitter ----------------
  state_e      tx_st_q, tx_st_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_sh_q, tx_sh_d;
  logic        tx_q, tx_d;
  logic        tx_busy;
  logic        tx_start;
  logic        tx_tick;

  assign tx_busy  = tx_st_q != S_IDLE;
  assign tx_start = we && sel_data && !tx_busy;
  assign tx_tick  = tx_cnt_q == DIV_M1;
  assign tx       = tx_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_st_q <= S_IDLE;
    end else begin
      tx_st_q <= tx_st_d;
    end
  end

  always_comb begin
    tx_st_d = tx_st_q;
    unique case (tx_st_q)
      S_IDLE:  if (tx_start) tx_st_d = S_START;
      S_START: if (tx_tick) tx_st_d = S_DATA;
      S_DATA:  if (tx_tick && tx_bit_q == 3'd7) tx_st_d = S_STOP;
      S_STOP:  if (tx_tick) tx_st_d = S_IDLE;
      default: tx_st_d = S_IDLE;
    endcase
  end

  // tx is registered: each state sets the level for the next bit at its tick
  always_comb begin
    tx_cnt_d = tx_tick ? 16'd0 : tx_cnt_q + 16'd1;
    tx_bit_d = tx_bit_q;
    tx_sh_d  = tx_sh_q;
    tx_d     = tx_q;
    unique case (tx_st_q)
      S_IDLE: begin
        tx_cnt_d = 16'd0;
        tx_bit_d = 3'd0;
        tx_d     = 1'b1;
        if (tx_start) begin
          tx_sh_d = d;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (tx_tick) tx_d = tx_sh_q[0];
      end
      S_DATA: begin
        if (tx_tick) begin
          tx_sh_d  = {1'b1, tx_sh_q[7:1]};
          tx_bit_d = tx_bit_q + 3'd1;
          tx_d     = (tx_bit_q == 3'd7) ? 1'b1 : tx_sh_q[1];
        end
      end
      S_STOP: begin
        tx_d = 1'b1;
      end
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_cnt_q <= 16'd0;
      tx_bit_q <= 3'd0;
      tx_sh_q  <= 8'h00;
      tx_q     <= 1'b1;
    end else begin
      tx_cnt_q <= tx_cnt_d;
      tx_bit_q <= tx_bit_d;
      tx_sh_q  <= tx_sh_d;
      tx_q     <= tx_d;
    end
  end

  // ---------------- receiver ----------------
  logic        rx_s1_q, rx_s2_q, rx_prev_q;
  state_e      rx_st_q, rx_st_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic        rx_tick;
  logic        rx_half;
  logic        rx_fall;
  logic        push;
  logic        ferr_set;

  assign rx_tick = rx_cnt_q == DIV_M1;
  assign rx_half = rx_cnt_q == HALF_M1;
  assign rx_fall = rx_prev_q && !rx_s2_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_st_q <= S_IDLE;
    end else begin
      rx_st_q <= rx_st_d;
    end
  end

  always_comb begin
    rx_st_d = rx_st_q;
    unique case (rx_st_q)
      S_IDLE:  if (rx_fall) rx_st_d = S_START;
      S_START: if (rx_half) rx_st_d = rx_s2_q ? S_IDLE : S_DATA;
      S_DATA:  if (rx_tick && rx_bit_q == 3'd7) rx_st_d = S_STOP;
      S_STOP:  if (rx_tick) rx_st_d = S_IDLE;
      default: rx_st_d = S_IDLE;
    endcase
  end

  always_comb begin
    rx_cnt_d = rx_cnt_q + 16'd1;
    rx_bit_d = rx_bit_q;
    rx_sh_d  = rx_sh_q;
    push     = 1'b0;
    ferr_set = 1'b0;
    unique case (rx_st_q)
      S_IDLE: begin
        rx_cnt_d = 16'd0;
        rx_bit_d = 3'd0;
      end
      S_START: begin
        if (rx_half) rx_cnt_d = 16'd0;
      end
      S_DATA: begin
        if (rx_tick) begin
          rx_cnt_d = 16'd0;
          rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
          rx_bit_d = rx_bit_q + 3'd1;
        end
      end
      S_STOP: begin
        if (rx_tick) begin
          rx_cnt_d = 16'd0;
          push     = 1'b1;
          ferr_set = !rx_s2_q;
        end
      end
      default: rx_cnt_d = 16'd0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
      rx_cnt_q  <= 16'd0;
      rx_bit_q  <= 3'd0;
      rx_sh_q   <= 8'h00;
    end else begin
      rx_s1_q   <= rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      rx_cnt_q  <= rx_cnt_d;
      rx_bit_q  <= rx_bit_d;
      rx_sh_q   <= rx_sh_d;
    end
  end

  // ---------------- receive buffer ----------------
  logic       pop;
  logic       full;
  logic       empty;
  logic       push_ok;
  logic       ovr_set;
  logic [7:0] head;

  assign pop     = read && sel_data && !empty;
  assign push_ok = push && (!full || pop);
  assign ovr_set = push && full && !pop;

`ifdef UART_RX_FIFO_EN
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [AW:0] wp_q, wp_d;
  logic [AW:0] rp_q, rp_d;
  logic [7:0]  mem_q [DEPTH];

  assign empty = wp_q == rp_q;
  assign full  = (wp_q[AW] != rp_q[AW]) &&
                 (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign head  = empty ? 8'h00 : mem_q[rp_q[AW-1:0]];

  always_comb begin
    wp_d = push_ok ? wp_q + PTR_ONE : wp_q;
    rp_d = pop ? rp_q + PTR_ONE : rp_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wp_q[AW-1:0]] <= rx_sh_q;
  end
`else
  logic [7:0] hold_q, hold_d;
  logic       vld_q, vld_d;

  assign empty = !vld_q;
  assign full  = vld_q;
  assign head  = vld_q ? hold_q : 8'h00;

  always_comb begin
    hold_d = push_ok ? rx_sh_q : hold_q;
    vld_d  = push_ok ? 1'b1 : (pop ? 1'b0 : vld_q);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hold_q <= 8'h00;
      vld_q  <= 1'b0;
    end else begin
      hold_q <= hold_d;
      vld_q  <= vld_d;
    end
  end
`endif

  // ---------------- status flags and bus ----------------
  logic ovr_q, ovr_d;
  logic ferr_q, ferr_d;

  // a new error on the clearing edge wins
  always_comb begin
    ovr_d  = (stat_wr ? 1'b0 : ovr_q) | ovr_set;
    ferr_d = (stat_wr ? 1'b0 : ferr_q) | ferr_set;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ovr_q  <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      ovr_q  <= ovr_d;
      ferr_q <= ferr_d;
    end
  end

  logic [7:0] status;

  assign status = {4'b0000, ferr_q, ovr_q, tx_busy, !empty};
  assign hit    = sel_data || sel_stat;
  assign intr   = !empty;

  always_comb begin
    q = 8'h00;
    unique case (1'b1)
      sel_data: q = head;
      sel_stat: q = status;
      default:  q = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_avr_uart.sv
// tb_avr_uart: directed bench for avr_uart with a queue-based reference model.
// Build with +define+UART_RX_FIFO_EN to exercise the DEPTH-entry FIFO.
module tb_avr_uart;

  localparam logic [15:0] BASE  = 16'h0020;
  localparam logic [15:0] STAT  = 16'h0021;
  localparam int          DIV   = 4;
  localparam int          DEPTH = 16;
`ifdef UART_RX_FIFO_EN
  localparam int          EFF   = DEPTH;
`else
  localparam int          EFF   = 1;
`endif
  localparam int          FRAME = 10 * DIV;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] address = 16'h0000;
  logic [7:0]  d = 8'h00;
  logic        we = 1'b0;
  logic        read = 1'b0;
  logic        rx = 1'b1;
  logic        hit;
  logic [7:0]  q;
  logic        tx;
  logic        intr;

  int vectors = 0;
  int errs = 0;

  always #5 clock = ~clock;

  avr_uart #(
    .BASE(BASE),
    .DIVISOR(DIV),
    .DEPTH(DEPTH)
  ) dut (
    .clock(clock),
    .reset(reset),
    .address(address),
    .d(d),
    .we(we),
    .read(read),
    .hit(hit),
    .q(q),
    .rx(rx),
    .tx(tx),
    .intr(intr)
  );

  // reference model: frame timeline for tx, byte queue for rx
  int         cyc = 0;
  bit         tx_act = 0;
  int         tx_t0 = 0;
  logic [7:0] tx_byte = 8'h00;
  logic [7:0] mq[$];
  bit         m_ovr = 0;
  bit         m_ferr = 0;
  bit         armed = 0;
  bit         rx_fly = 0;

  function automatic bit m_busy();
    return tx_act && (cyc - tx_t0) < FRAME;
  endfunction

  function automatic logic exp_tx();
    int k;
    if (!m_busy()) return 1'b1;
    k = (cyc - tx_t0) / DIV;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return tx_byte[k-1];
  endfunction

  function automatic logic [7:0] exp_q();
    logic [7:0] st;
    st = {4'b0000, m_ferr, m_ovr, m_busy(), mq.size() != 0};
    if (address == BASE) return (mq.size() != 0) ? mq[0] : 8'h00;
    if (address == STAT) return st;
    return 8'h00;
  endfunction

  task automatic chk8(input string nm, input logic [7:0] act,
                      input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %02h expected %02h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %b expected %b at t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clock) begin
    bit busy_before;
    busy_before = m_busy();
    cyc++;
    if (reset) begin
      tx_act = 0;
      mq.delete();
      m_ovr = 0;
      m_ferr = 0;
    end else begin
      if (we && address == BASE && !busy_before) begin
        tx_act = 1;
        tx_t0 = cyc;
        tx_byte = d;
      end
      if (we && address == STAT) begin
        m_ovr = 0;
        m_ferr = 0;
      end
      if (read && address == BASE && mq.size() != 0) void'(mq.pop_front());
    end
  end

  always begin
    @(posedge clock);
    #1;
    if (armed) begin
      chk1("tx", tx, exp_tx());
      chk1("hit", hit, (address == BASE) || (address == STAT));
      if (!rx_fly) begin
        chk1("intr", intr, mq.size() != 0);
        chk8("q", q, exp_q());
      end
    end
  end

  task automatic cpu_wr(input logic [15:0] a, input logic [7:0] v);
    @(negedge clock);
    address = a;
    d = v;
    we = 1'b1;
    @(negedge clock);
    we = 1'b0;
  endtask

  task automatic cpu_rd(input logic [15:0] a, input logic [7:0] exp,
                        input string nm);
    @(negedge clock);
    address = a;
    read = 1'b1;
    #1;
    chk8(nm, q, exp);
    @(negedge clock);
    read = 1'b0;
  endtask

  task automatic chk_stat(input logic [7:0] exp, input string nm);
    @(negedge clock);
    address = STAT;
    #1;
    chk8(nm, q, exp);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    rx_fly = 1;
    @(negedge clock);
    for (int i = 0; i < 10; i++) begin
      if (i == 0) rx = 1'b0;
      else if (i == 9) rx = stop;
      else rx = b[i-1];
      repeat (DIV) @(negedge clock);
    end
    rx = 1'b1;
    repeat (3 * DIV) @(negedge clock);
    if (mq.size() < EFF) mq.push_back(b);
    else m_ovr = 1;
    if (!stop) m_ferr = 1;
    rx_fly = 0;
  endtask

  task automatic send_glitch();
    rx_fly = 1;
    @(negedge clock);
    rx = 1'b0;
    @(negedge clock);
    rx = 1'b1;
    repeat (3 * DIV) @(negedge clock);
    rx_fly = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: no finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] a5_frame;
    a5_frame = 10'b1101001010;

    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    armed = 1;
    chk1("rst_tx", tx, 1'b1);
    chk1("rst_intr", intr, 1'b0);
    chk_stat(8'h00, "rst_status");

    // transmit A5, second write while busy is dropped
    cpu_wr(BASE, 8'hA5);
    cpu_wr(BASE, 8'h3C);
    address = STAT;
    for (int k = 0; k < 10; k++) begin
      if (k != 0) repeat (DIV) @(negedge clock);
      #1;
      chk1("tx_a5_bit", tx, a5_frame[k]);
      chk8("tx_busy_status", q, 8'h02);
    end
    repeat (DIV) @(negedge clock);
    #1;
    chk1("tx_idle_after", tx, 1'b1);
    chk8("tx_done_status", q, 8'h00);
    repeat (2 * FRAME) @(negedge clock);

    // single receive
    send_rx(8'h5A, 1'b1);
    chk1("rx_intr", intr, 1'b1);
    chk_stat(8'h01, "rx_status");
    cpu_rd(BASE, 8'h5A, "rx_data_5a");
    chk_stat(8'h00, "rx_status_empty");
    chk1("rx_intr_clear", intr, 1'b0);

    // overflow: one frame more than the buffer holds
    for (int i = 0; i <= EFF; i++) send_rx(8'(8'h10 + i), 1'b1);
    chk_stat(8'h05, "ovr_status");
    for (int i = 0; i < EFF; i++) cpu_rd(BASE, 8'(8'h10 + i), "ovr_data");
    chk_stat(8'h04, "ovr_after_drain");
    cpu_rd(BASE, 8'h00, "empty_read");
    cpu_wr(STAT, 8'h00);
    chk_stat(8'h00, "ovr_cleared");

    // framing error keeps the byte
    send_rx(8'h81, 1'b0);
    chk_stat(8'h09, "ferr_status");
    cpu_wr(STAT, 8'hFF);
    chk_stat(8'h01, "ferr_cleared");
    cpu_rd(BASE, 8'h81, "ferr_data");
    chk_stat(8'h00, "ferr_empty");

    // one-clock glitch stores nothing
    send_glitch();
    chk_stat(8'h00, "glitch_status");
    chk1("glitch_intr", intr, 1'b0);

    // reset in the middle of a frame
    cpu_wr(BASE, 8'h00);
    repeat (10) @(negedge clock);
    #1;
    chk1("mid_tx_low", tx, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk1("reset_tx_high", tx, 1'b1);
    chk_stat(8'h00, "reset_status");

    // a frame after reset runs normally
    cpu_wr(BASE, 8'hC3);
    repeat (FRAME + 8) @(negedge clock);
    chk_stat(8'h00, "final_status");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
